// File: rtl/pcileech_board_pkg.sv
// Shared definitions for the board control block: reset FSM states and
// default timing constants (cycles of the 100 MHz system clock).
// No logic; imported by pcileech_debounce and pcileech_board_ctl.
package pcileech_board_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        HOLD   = 2'd1,
        IDLE   = 2'd2
    } rst_state_t;

    localparam int DEF_DEBOUNCE_CYCLES    = 1000000;   // 10 ms at 100 MHz
    localparam int DEF_RST_STRETCH_CYCLES = 256;
    localparam int DEF_ACT_STRETCH_CYCLES = 5000000;   // 50 ms at 100 MHz
    localparam int DEF_BLINK_HALF_CYCLES  = 50000000;  // 0.5 s at 100 MHz

endpackage

// File: rtl/pcileech_debounce.sv
// Purpose: 2-flop synchronizer plus counter debounce for one active-low button.
// Latency: a clean raw edge reaches 'pressed' exactly 2+DEBOUNCE_CYCLES cycles later.
// Backpressure: none; free-running level output.
//
// Ports: clk (system clock), rst_n (sync active-low reset), btn_raw_n (raw
// asynchronous button, low = pressed), pressed (debounced level, high = pressed).
module pcileech_debounce
    import pcileech_board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_n,
    output logic pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The stable value is kept in pressed polarity (pressed == ~stable) so the
    // debounced output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            sync1 <= btn_raw_n;
            sync2 <= sync1;
            if (sync2 == ~pressed) begin
                cnt <= '0;                  // agrees with stable value, or bounced back
            end else if (cnt == CNT_LAST) begin
                pressed <= ~sync2;          // differed for DEBOUNCE_CYCLES cycles
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pcileech_board_ctl.sv
// Purpose: board control - debounced buttons, stretched system reset, user LED.
// Latency: rst_out rises 1 cycle after a debounced press; led_out is 1 cycle behind its inputs.
// Backpressure: none; all outputs are free-running status levels.
//
// Ports: clk (100 MHz), rst_n (sync active-low), btn_rst_n / btn_inv_n (raw
// buttons, low = pressed), led_act (activity pulse), rst_out (active-high
// system reset), btn_inv (debounced invert, high = pressed), led_out (LED).
// Build option: define PCILEECH_BOARD_HEARTBEAT_EN to blink the LED while idle.
module pcileech_board_ctl
    import pcileech_board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
    parameter int RST_STRETCH_CYCLES = DEF_RST_STRETCH_CYCLES,
    parameter int ACT_STRETCH_CYCLES = DEF_ACT_STRETCH_CYCLES,
    parameter int BLINK_HALF_CYCLES  = DEF_BLINK_HALF_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_rst_n,
    input  logic btn_inv_n,
    input  logic led_act,
    output logic rst_out,
    output logic btn_inv,
    output logic led_out
);

    localparam int SW = $clog2(RST_STRETCH_CYCLES + 1);
    localparam int AW = $clog2(ACT_STRETCH_CYCLES + 1);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(RST_STRETCH_CYCLES - 1);
    localparam logic [AW-1:0] ACT_LOAD     = AW'(ACT_STRETCH_CYCLES);

    logic rst_pressed;

    pcileech_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw_n (btn_rst_n),
        .pressed   (rst_pressed)
    );

    pcileech_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inv (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw_n (btn_inv_n),
        .pressed   (btn_inv)
    );

    // ---------------- reset stretch FSM ----------------
    rst_state_t    state;
    rst_state_t    state_nxt;
    logic [SW-1:0] st_cnt;
    logic [SW-1:0] st_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ASSERT;
            st_cnt <= '0;
        end else begin
            state  <= state_nxt;
            st_cnt <= st_cnt_nxt;
        end
    end

    // Button activity is ignored in ASSERT so the stretch always runs in full;
    // HOLD then waits for the button to be let go.
    always_comb begin
        state_nxt  = state;
        st_cnt_nxt = st_cnt;
        case (state)
            ASSERT: begin
                if (st_cnt == STRETCH_LAST) begin
                    state_nxt  = HOLD;
                    st_cnt_nxt = '0;
                end else begin
                    st_cnt_nxt = st_cnt + SW'(1);
                end
            end
            HOLD: begin
                if (!rst_pressed) state_nxt = IDLE;
            end
            IDLE: begin
                if (rst_pressed) begin
                    state_nxt  = ASSERT;
                    st_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt  = ASSERT;
                st_cnt_nxt = '0;
            end
        endcase
    end

    assign rst_out = (state != IDLE);

    // ---------------- activity stretch ----------------
    logic [AW-1:0] act_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_cnt <= '0;
        end else if (led_act) begin
            act_cnt <= ACT_LOAD;
        end else if (act_cnt != '0) begin
            act_cnt <= act_cnt - AW'(1);
        end
    end

    // ---------------- idle LED value ----------------
    logic idle_val;

`ifdef PCILEECH_BOARD_HEARTBEAT_EN
    localparam int BW = $clog2(BLINK_HALF_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Frozen while the system is held in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!rst_out) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign idle_val = blink_phase;
`else
    assign idle_val = 1'b0;
`endif

    // ---------------- LED drive ----------------
    logic led_base;

    always_comb begin
        led_base = 1'b0;
        if (!rst_out) led_base = (act_cnt != '0) | idle_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) led_out <= 1'b0;
        else        led_out <= led_base ^ btn_inv;
    end

endmodule

// File: tb/tb_pcileech_board_ctl.sv
// Bench for pcileech_board_ctl with small timing parameters. A time-based
// model (edge indices, sample windows) predicts rst_out, btn_inv and led_out
// every cycle; directed scenarios add literal latency expectations.
module tb_pcileech_board_ctl;

    localparam int D = 8;
    localparam int R = 4;
    localparam int A = 16;
    localparam int B = 32;

    logic clk = 1'b0;
    logic rst_n, btn_rst_n, btn_inv_n, led_act;
    logic rst_out, btn_inv, led_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcileech_board_ctl #(
        .DEBOUNCE_CYCLES    (D),
        .RST_STRETCH_CYCLES (R),
        .ACT_STRETCH_CYCLES (A),
        .BLINK_HALF_CYCLES  (B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_rst_n (btn_rst_n),
        .btn_inv_n (btn_inv_n),
        .led_act   (led_act),
        .rst_out   (rst_out),
        .btn_inv   (btn_inv),
        .led_out   (led_out)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Edge n samples the inputs present just before it. A button's synced
    // value seen at edge n is the raw sample of edge n-2; the debounced value
    // flips once the D synced samples ending there all disagree with it.
    int n = 0;
    int t0 = 0;            // edge at which the current reset request began
    bit rel_seen = 1'b0;   // button seen released after the stretch ended
    int la = -1000000;     // last edge at which led_act was sampled high
    int hb_n = 0;          // edges spent with rst_out low since reset
    bit db_rst_n = 1'b1, db_inv_n = 1'b1;
    bit q_rst[$], q_inv[$];
    bit m_rst_out = 1'b1, m_btn_inv = 1'b0, m_led = 1'b0, m_act_nz = 1'b0, m_phase = 1'b0;
    bit chk_en = 1'b0;

    function automatic bit window_flip(input bit q[$], input bit db);
        int sz;
        sz = q.size();
        if (sz < D + 2) return 1'b0;
        for (int i = sz - 2 - D; i <= sz - 3; i++)
            if (q[i] == db) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit rst_pre, prs_pre, inv_pre, act_pre, phase_pre, base;
        rst_pre   = m_rst_out;
        prs_pre   = !db_rst_n;
        inv_pre   = m_btn_inv;
        act_pre   = m_act_nz;
        phase_pre = m_phase;
        n++;
        if (!rst_n) begin
            t0 = n; rel_seen = 1'b0; la = -1000000; hb_n = 0;
            q_rst.delete(); q_inv.delete();
            q_rst.push_back(1'b1); q_rst.push_back(1'b1);
            q_inv.push_back(1'b1); q_inv.push_back(1'b1);
            db_rst_n = 1'b1; db_inv_n = 1'b1;
            m_led = 1'b0;
        end else begin
            q_rst.push_back(btn_rst_n);
            q_inv.push_back(btn_inv_n);
            while (q_rst.size() > D + 2) void'(q_rst.pop_front());
            while (q_inv.size() > D + 2) void'(q_inv.pop_front());
            if (window_flip(q_rst, db_rst_n)) db_rst_n = !db_rst_n;
            if (window_flip(q_inv, db_inv_n)) db_inv_n = !db_inv_n;
            if (led_act) la = n;
            if (!rst_pre) begin
                if (prs_pre) begin t0 = n; rel_seen = 1'b0; end
            end else if (n > t0 + R && !prs_pre) begin
                rel_seen = 1'b1;
            end
            if (!rst_pre) hb_n++;
            base  = rst_pre ? 1'b0 : (act_pre ? 1'b1 : phase_pre);
            m_led = base ^ inv_pre;
        end
        m_rst_out = !rel_seen;
        m_btn_inv = !db_inv_n;
        m_act_nz  = rst_n && ((n - la) < A);
`ifdef PCILEECH_BOARD_HEARTBEAT_EN
        m_phase = ((hb_n / B) % 2) == 1;
`else
        m_phase = 1'b0;
`endif
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_bit("model rst_out", rst_out, m_rst_out);
            check_bit("model btn_inv", btn_inv, m_btn_inv);
            check_bit("model led_out", led_out, m_led);
        end
    end

    // LED high-time counter for the activity scenario
    bit led_win = 1'b0;
    int led_hi = 0;
    always @(negedge clk) if (led_win && led_out === 1'b1) led_hi++;

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until the selected output takes 'val'; -1 on timeout.
    task automatic wait_for(input int sel, input logic val, input int bound, output int k);
        logic s;
        k = 0;
        while (k < bound) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            s = (sel == 0) ? rst_out : (sel == 1) ? btn_inv : led_out;
            if (s === val) return;
        end
        k = -1;
    endtask

    int k;
    int rem_r = 0, rem_i = 0;

    initial begin
        rst_n = 1'b0; btn_rst_n = 1'b1; btn_inv_n = 1'b1; led_act = 1'b0;
        repeat (3) tick();
        check_bit("reset rst_out", rst_out, 1'b1);
        check_bit("reset btn_inv", btn_inv, 1'b0);
        check_bit("reset led_out", led_out, 1'b0);

        // Power-up: R cycles of ASSERT plus one HOLD cycle (button already up).
        rst_n = 1'b1;
        wait_for(0, 1'b0, 50, k);
        check_int("powerup stretch", k, R + 1);
        repeat (5) tick();

        // Bounced press: low 5, high 1, low; press accepted D+2 after last fall.
        btn_rst_n = 1'b0; repeat (5) tick();
        btn_rst_n = 1'b1; tick();
        btn_rst_n = 1'b0;
        wait_for(0, 1'b1, 40, k);
        check_int("bounce press rst_out", k, D + 3);
        repeat (10) tick();
        btn_rst_n = 1'b1;
        repeat (20) tick();

        // Long press: rst_out held until debounced release plus one FSM cycle.
        btn_rst_n = 1'b0;
        repeat (100) tick();
        check_bit("long press held", rst_out, 1'b1);
        btn_rst_n = 1'b1;
        wait_for(0, 1'b0, 40, k);
        check_int("long press release", k, D + 3);
        repeat (5) tick();

        // Activity pulses t and t+10: LED high t+1..t+26.
        led_act = 1'b1; led_hi = 0; led_win = 1'b1;
        tick(); led_act = 1'b0;
        repeat (9) tick();
        led_act = 1'b1; tick(); led_act = 1'b0;
        repeat (60) tick();
        led_win = 1'b0;
`ifndef PCILEECH_BOARD_HEARTBEAT_EN
        check_int("activity led cycles", led_hi, 26);
`endif

        // Invert button with LED idle.
        btn_inv_n = 1'b0;
        wait_for(1, 1'b1, 40, k);
        check_int("invert latency", k, D + 2);
`ifndef PCILEECH_BOARD_HEARTBEAT_EN
        @(posedge clk); @(negedge clk);
        check_bit("inverted idle led", led_out, 1'b1);
`endif
        repeat (15) tick();
        btn_inv_n = 1'b1;
        repeat (20) tick();

        // Idle stretch (heartbeat visible only when enabled).
        repeat (200) tick();

        // Random phase: button segments of mixed length, sparse activity, rare resets.
        repeat (3000) begin
            if (rem_r == 0) begin btn_rst_n = 1'($urandom_range(0, 1)); rem_r = $urandom_range(1, 30); end
            if (rem_i == 0) begin btn_inv_n = 1'($urandom_range(0, 1)); rem_i = $urandom_range(1, 30); end
            rem_r--; rem_i--;
            led_act = ($urandom_range(0, 15) == 0);
            rst_n   = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1; btn_rst_n = 1'b1; btn_inv_n = 1'b1; led_act = 1'b0;
        repeat (50) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
